// File: rtl/zx_cart_pkg.sv
// Shared constants for the ZX Spectrum cartridge controller.
package zx_cart_pkg;

    localparam int unsigned CR_ROM_AW   = 6;
    localparam logic [2:0]  LOW_ROM_WIN = 3'b000;

endpackage

// File: rtl/zx_cart_port_strobe.sv
// Synchronises IORQ/A7 into clk and emits a 1-clk pulse on each IORQ falling edge with A7=0.
module zx_cart_port_strobe
    import zx_cart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_iorq_n,
    input  logic i_a7,
    output logic o_inc
);

    logic       r_iorq_s1;
    logic       r_iorq_s2;
    logic       r_iorq_hist;
    logic       r_a7_s1;
    logic       r_a7_s2;
    logic [2:0] r_vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_iorq_s1   <= 1'b1;
            r_iorq_s2   <= 1'b1;
            r_iorq_hist <= 1'b1;
            r_a7_s1     <= 1'b1;
            r_a7_s2     <= 1'b1;
            r_vld       <= '0;
        end else begin
            r_iorq_s1   <= i_iorq_n;
            r_iorq_s2   <= r_iorq_s1;
            r_iorq_hist <= r_iorq_s2;
            r_a7_s1     <= i_a7;
            r_a7_s2     <= r_a7_s1;
            r_vld       <= {r_vld[1:0], 1'b1};
        end
    end

    // r_vld marks when the history flop holds a real sample, so an IORQ held low
    // across reset release is not seen as a falling edge against the idle value.
    assign o_inc = r_vld[2] & r_iorq_hist & ~r_iorq_s2 & ~r_a7_s2;

endmodule

// File: rtl/zx_cartridge.sv
// Cartridge controller: bank counter with self-lock and lower-ROM bus decode.
module zx_cartridge
    import zx_cart_pkg::*;
#(
    parameter int unsigned SELF_LOCK_VAL = 63
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 iorq_n,
    input  logic                 rd_n,
    input  logic                 mreq_n,
    input  logic                 A7,
    input  logic                 A13,
    input  logic                 A14,
    input  logic                 A15,
    output logic                 ZX_ROM_blk,
    output logic                 CR_ROM_oe_n,
    output logic [CR_ROM_AW-1:0] CR_ROM_A
);

    logic [CR_ROM_AW-1:0] r_bank;
    logic                 w_inc;
    logic                 w_lock;
    logic                 w_cr_sel;

    zx_cart_port_strobe u_strobe (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_iorq_n (iorq_n),
        .i_a7     (A7),
        .o_inc    (w_inc)
    );

    assign w_lock = (r_bank == CR_ROM_AW'(SELF_LOCK_VAL));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bank <= '0;
        end else if (w_inc && !w_lock) begin
            r_bank <= r_bank + 1'b1;
        end
    end

    always_comb begin
        w_cr_sel = ~mreq_n & ~rd_n & ({A15, A14, A13} == LOW_ROM_WIN) & ~w_lock;
    end

    assign CR_ROM_oe_n = ~w_cr_sel;
    assign ZX_ROM_blk  = w_cr_sel;
    assign CR_ROM_A    = r_bank;

endmodule

// File: tb/tb_zx_cartridge.sv
// Scoreboard bench for zx_cartridge with SELF_LOCK_VAL=3.
module tb_zx_cartridge;

    localparam int unsigned LOCK = 3;

    logic       clk;
    logic       reset_n;
    logic       iorq_n;
    logic       rd_n;
    logic       mreq_n;
    logic       A7;
    logic       A13;
    logic       A14;
    logic       A15;
    logic       ZX_ROM_blk;
    logic       CR_ROM_oe_n;
    logic [5:0] CR_ROM_A;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks;
    int         n_fail;
    int unsigned m_bank;

    zx_cartridge #(.SELF_LOCK_VAL(LOCK)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .mreq_n      (mreq_n),
        .A7          (A7),
        .A13         (A13),
        .A14         (A14),
        .A15         (A15),
        .ZX_ROM_blk  (ZX_ROM_blk),
        .CR_ROM_oe_n (CR_ROM_oe_n),
        .CR_ROM_A    (CR_ROM_A)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got blk=%0b oe_n=%0b A=%0d, expected blk=%0b oe_n=%0b A=%0d",
                     tag, got[7], got[6], got[5:0], exp[7], exp[6], exp[5:0]);
        end
    endtask

    function automatic logic [7:0] model_out(input logic [15:0] addr, input logic mq, input logic rd);
        logic sel;
        sel = !mq && !rd && (addr[15:13] == 3'b000) && (m_bank != LOCK);
        return {sel, !sel, 6'(m_bank)};
    endfunction

    task automatic push_exp(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: observed output with empty expect queue");
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, {ZX_ROM_blk, CR_ROM_oe_n, CR_ROM_A}, e.val);
        end
    endtask

    task automatic set_addr(input logic [15:0] addr);
        A7  = addr[7];
        A13 = addr[13];
        A14 = addr[14];
        A15 = addr[15];
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_pulse(input string tag, input logic [15:0] addr, input int low_cyc);
        @(negedge clk);
        set_addr(addr);
        iorq_n = 1'b0;
        wait_cyc(low_cyc);
        iorq_n = 1'b1;
        if (!addr[7] && m_bank != LOCK) m_bank++;
        push_exp(tag, model_out(addr, mreq_n, rd_n));
        wait_cyc(4);
        pop_cmp();
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] addr, input logic mq, input logic rd);
        @(negedge clk);
        set_addr(addr);
        mreq_n = mq;
        rd_n   = rd;
        push_exp(tag, model_out(addr, mq, rd));
        #1;
        pop_cmp();
        mreq_n = 1'b1;
        rd_n   = 1'b1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0;
        wait_cyc(n);
        reset_n = 1'b1;
        m_bank  = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_bank   = 0;
        reset_n  = 1'b0;
        iorq_n   = 1'b1;
        rd_n     = 1'b1;
        mreq_n   = 1'b1;
        set_addr(16'h0000);
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(2);
        push_exp("reset_state", model_out(16'h0000, 1'b1, 1'b1));
        pop_cmp();

        io_pulse("io_a7_high", 16'h0080, 4);
        io_pulse("io_first", 16'h007F, 4);
        io_pulse("io_long_pulse", 16'h007F, 15);
        io_pulse("io_lock", 16'h007F, 3);
        io_pulse("io_after_lock", 16'h007F, 5);
        bus_rd("rd_locked", 16'h0100, 1'b0, 1'b0);

        do_reset(2);
        wait_cyc(1);
        push_exp("reset_again", model_out(16'h0100, 1'b1, 1'b1));
        pop_cmp();

        bus_rd("rd_mreq_only", 16'h0100, 1'b0, 1'b1);
        bus_rd("rd_rd_only", 16'h0100, 1'b1, 1'b0);
        bus_rd("rd_0100", 16'h0100, 1'b0, 1'b0);
        bus_rd("rd_1fff", 16'h1FFF, 1'b0, 1'b0);
        bus_rd("rd_2000", 16'h2000, 1'b0, 1'b0);
        bus_rd("rd_4001", 16'h4001, 1'b0, 1'b0);

        // Reset while IORQ is held low, released with IORQ still low.
        @(negedge clk);
        set_addr(16'h007F);
        iorq_n = 1'b0;
        wait_cyc(2);
        do_reset(2);
        wait_cyc(8);
        iorq_n = 1'b1;
        wait_cyc(4);
        push_exp("reset_iorq_low", model_out(16'h007F, 1'b1, 1'b1));
        pop_cmp();

        io_pulse("io_post_reset", 16'h007F, 4);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zx_cartridge.md
Name: zx_cartridge

Overview:
- ZX Spectrum cartridge controller: maps a cartridge ROM into Z80 address space 0x0000–0x1FFF and blocks the internal ZX ROM while the cartridge drives the bus.
- A 6-bit bank counter (cartridge ROM high address lines) advances on each I/O cycle whose A7=0.
- When the counter reaches SELF_LOCK_VAL, the block locks: the cartridge ROM is disabled and the counter freezes until reset.
- Sits between the Z80 edge connector and the cartridge ROM chip.

Parameters:
- SELF_LOCK_VAL, default 63: counter value at which the block self-locks. Legal range 1..63; 0 means locked immediately out of reset.

Ports:
- clk  input  1  system clock; must run at least 4x faster than the shortest iorq_n low pulse.
- reset_n  input  1  synchronous, active-low reset.
- iorq_n  input  1  Z80 IORQ, active low, asynchronous to clk.
- rd_n  input  1  Z80 RD, active low.
- mreq_n  input  1  Z80 MREQ, active low.
- A7  input  1  Z80 address bit 7; port decode, increment only when 0.
- A13  input  1  Z80 address bit 13.
- A14  input  1  Z80 address bit 14.
- A15  input  1  Z80 address bit 15.
- ZX_ROM_blk  output  1  active high; blocks the internal ZX ROM.
- CR_ROM_oe_n  output  1  active-low output enable of the cartridge ROM.
- CR_ROM_A  output  6  cartridge ROM bank address, equal to the counter.

Behaviour:
- Clocking and reset: one clock (clk); reset_n is synchronous and active-low.
- Reset, sampled at a clk rising edge with reset_n=0:
  - CR_ROM_A=0, lock cleared.
  - Synchronizer and edge-detect flops forced to idle (iorq history = 1), so no spurious increment on reset release.
  - Reset asserted mid-cycle wins over any pending increment.
- Lock: self_lock = (CR_ROM_A == SELF_LOCK_VAL), derived combinationally from the counter register.
- Input synchronization: iorq_n and A7 are captured together through a 2-flop synchronizer, followed by a history flop for iorq_n.
- Increment event: synced iorq_n falls (history=1, current=0) AND synced A7=0 AND self_lock=0.
  - Effect: CR_ROM_A <= CR_ROM_A + 1.
  - Latency: new value visible after the 3rd clk rising edge following the iorq_n falling edge.
  - Only one increment per iorq_n low pulse, however long the pulse lasts.
- No-increment cases:
  - A7=1 at the falling edge.
  - iorq_n rising edges.
  - mreq/rd activity.
  - Any event while self_lock=1.
- Counter arithmetic: 6-bit; saturates by lock at SELF_LOCK_VAL and never wraps, since the lock value is at most 63.
- Cartridge enable (combinational, no clock latency, for bus timing):
  - CR_ROM_oe_n = 0 iff mreq_n=0 AND rd_n=0 AND A15=0 AND A14=0 AND A13=0 AND self_lock=0.
  - Otherwise CR_ROM_oe_n = 1.
- ZX_ROM_blk = NOT CR_ROM_oe_n, also combinational.
- Values out of reset: CR_ROM_oe_n=1, ZX_ROM_blk=0 (bus idle), CR_ROM_A=0.
- Lock taking effect: the first read after lock has CR_ROM_oe_n=1 and ZX_ROM_blk=0. It takes effect in the same clk edge that loads the final count.
- Write/read cycles (mreq_n, rd_n) do not affect the counter; IORQ reads with A7=0 (IN) also increment, since rd_n is not qualified.

Decomposition:
- Shared package zx_cart_pkg:
  - CR_ROM_AW = 6 (bank address width).
  - Localparam for the lower-ROM window decode (A15..A13 = 3'b000).
- One sub-module zx_cart_port_strobe: 2-flop synchronizer plus falling-edge detector for iorq_n, with A7 qualification; outputs a 1-clk increment pulse.
- Top module holds the counter, the lock compare and the combinational bus decode.

Test Plan (bench uses SELF_LOCK_VAL=3):
- Reset, then IORQ pulse at address 0x0080 (A7=1) -> CR_ROM_A stays 0.
- Two IORQ pulses at address 0x007F, iorq_n low ≥ 3 clk each -> CR_ROM_A=1 after first, 2 after second, one increment per pulse.
- Third pulse at 0x007F -> CR_ROM_A=3 and locked; fourth pulse -> CR_ROM_A stays 3. Read at 0x0100 (mreq_n=rd_n=0) -> CR_ROM_oe_n=1, ZX_ROM_blk=0.
- reset_n low for 2 clk, then high -> CR_ROM_A=0, CR_ROM_oe_n=1, unlocked.
- Unlocked, address 0x0100:
  - mreq_n=0, rd_n=1 -> oe_n=1.
  - mreq_n=1, rd_n=0 -> oe_n=1.
  - both 0 -> CR_ROM_oe_n=0, ZX_ROM_blk=1.
  - Same check at 0x1FFF -> oe_n=0.
  - At 0x2000 and 0x4001 -> oe_n=1, blk=0.
- Assert reset_n while iorq_n is held low at 0x007F, release with iorq_n still low -> CR_ROM_A stays 0 (no spurious edge).
